// File: rtl/pheap_level_pkg.sv
// Shared types, constants and comparison helpers for the pipelined-heap levels.
package pheap_level_pkg;

  localparam int unsigned LEVELS = 3;
  localparam int unsigned KEY_W  = 8;
  localparam int unsigned VAL_W  = 8;
  // Wide enough for the largest subtree capacity, 2^(LEVELS-1)-1.
  localparam int unsigned CAP_W  = LEVELS;

  typedef struct packed {
    logic [KEY_W-1:0] key;
    logic [VAL_W-1:0] val;
  } kv_t;

  typedef struct packed {
    kv_t              kv;
    logic [CAP_W-1:0] cap;
    logic             active;
  } entry_t;

  typedef enum logic [1:0] {
    OpLeq    = 2'd0,
    OpDeq    = 2'd1,
    OpEnqDeq = 2'd2
  } opcode_t;

  typedef enum logic [1:0] {
    DoneWait      = 2'd0,
    DoneNextLevel = 2'd1,
    DoneDone      = 2'd2
  } done_t;

  localparam kv_t    KV_EMPTY    = '{key: '0, val: '0};
  localparam kv_t    KV0         = '{key: '0, val: '0};
  localparam entry_t ENTRY_EMPTY = '{kv: KV_EMPTY, cap: '0, active: 1'b0};

  // A key/value beats an entry when the entry is empty or holds a smaller key.
  function automatic logic cmp_kv_entry_gt(kv_t a, entry_t b);
    return !b.active || (a.key > b.kv.key);
  endfunction

  // An inactive entry loses every comparison, including against another inactive one.
  function automatic logic cmp_entry_entry_gt(entry_t a, entry_t b);
    return a.active && (!b.active || (a.kv.key > b.kv.key));
  endfunction

  // Number of slots in the subtree rooted at one node of the given level.
  function automatic logic [CAP_W-1:0] subtree_cap(int unsigned level);
    int unsigned n;
    n = (32'd1 << (LEVELS - level + 1)) - 32'd1;
    return n[CAP_W-1:0];
  endfunction

endpackage

// File: rtl/pheap_level_if.sv
// Token + child-pair read link between two adjacent heap levels.
// The upper level is the master: it drives the token and the read address,
// the lower level returns the addressed child pair.
interface pheap_level_if
  import pheap_level_pkg::*;
#(
  parameter int unsigned POS_W = 1
) ();

  localparam int unsigned RA_W = (POS_W > 1) ? POS_W - 1 : 1;

  logic            start;
  opcode_t         op;
  kv_t             kv;
  logic [POS_W-1:0] pos;
  logic [RA_W-1:0] raddr;
  entry_t          rd_l;
  entry_t          rd_r;

  modport master (
    output start, op, kv, pos, raddr,
    input  rd_l, rd_r
  );

  modport slave (
    input  start, op, kv, pos, raddr,
    output rd_l, rd_r
  );

endinterface

// File: rtl/pheap_level_mem.sv
// Node storage for one heap level: reset-initialised register array with one
// write port, a write-first child-pair read port and a plain read of the node.
module pheap_level_mem
  import pheap_level_pkg::*;
#(
  parameter int unsigned      AW        = 1,
  parameter int unsigned      NODES     = 2,
  parameter int unsigned      RA_W      = 1,
  parameter logic [CAP_W-1:0] RESET_CAP = '1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  entry_t          wdata_i,
  input  logic [RA_W-1:0] raddr_i,
  output entry_t          rd_l_o,
  output entry_t          rd_r_o,
  input  logic [AW-1:0]   taddr_i,
  output entry_t          t_o
);

  entry_t        mem_q [NODES];
  entry_t        mem_d [NODES];
  logic [AW-1:0] addr_l;
  logic [AW-1:0] addr_r;

  if (AW == 1) begin : g_root_pair
    // The level-2 pair is the whole array; the parent index carries no information.
    logic unused_raddr;
    assign unused_raddr = ^raddr_i;
    assign addr_l       = 1'b0;
    assign addr_r       = 1'b1;
  end else begin : g_pair
    assign addr_l = {raddr_i[AW-2:0], 1'b0};
    assign addr_r = {raddr_i[AW-2:0], 1'b1};
  end

  // Next memory image; reading the pair from it gives write-first bypass.
  always_comb begin
    for (int i = 0; i < NODES; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (we_i) begin
      mem_d[waddr_i] = wdata_i;
    end
  end

  assign rd_l_o = mem_d[addr_l];
  assign rd_r_o = mem_d[addr_r];
  assign t_o    = mem_q[taddr_i];

  // Every node starts empty with the full capacity of its subtree.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NODES; i++) begin
        mem_q[i] <= '{kv: KV_EMPTY, cap: RESET_CAP, active: 1'b0};
      end
    end else begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/pheap_level.sv
// One pipelined-heap stage (LEVEL >= 2): accepts a token from the level above,
// performs LEQ/DEQ/ENQ_DEQ on one node in a single EXEC cycle, and either
// finishes or forwards the token to the level below.
module pheap_level
  import pheap_level_pkg::*;
#(
  parameter int unsigned LEVEL = 2,
  parameter bit          LAST  = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  pheap_level_if.slave  up,
  pheap_level_if.master dn,
  output done_t         done,
  output logic          active,
  output logic          err
);

  localparam int unsigned      PW        = LEVEL - 1;
  localparam int unsigned      NODES     = 1 << PW;
  localparam int unsigned      RA_W      = (LEVEL > 2) ? LEVEL - 2 : 1;
  localparam logic [CAP_W-1:0] RESET_CAP = subtree_cap(LEVEL);
  localparam logic [CAP_W-1:0] CAP_ONE   = 1;

  typedef enum logic [0:0] {
    StIdle,
    StExec
  } state_e;

  state_e          state_q, state_d;
  opcode_t         op_q, op_d;
  kv_t             in_q, in_d;
  logic [PW-1:0]   pos_q, pos_d;

  entry_t          t;
  entry_t          l;
  entry_t          r;
  entry_t          wdata;
  logic            we;
  logic            endbit;
  logic            start_dn;
  kv_t             out_dn;
  logic [PW-1:0]   raddr_dn;
  logic [CAP_W-1:0] cap_dec;
  logic [CAP_W-1:0] cap_inc;
  logic            in_gt_t;
  logic            l_room;
  logic            r_room;

  pheap_level_mem #(
    .AW       (PW),
    .NODES    (NODES),
    .RA_W     (RA_W),
    .RESET_CAP(RESET_CAP)
  ) u_mem (
    .clk    (clk),
    .rst_n  (rst_n),
    .we_i   (we),
    .waddr_i(pos_q),
    .wdata_i(wdata),
    .raddr_i(up.raddr),
    .rd_l_o (up.rd_l),
    .rd_r_o (up.rd_r),
    .taddr_i(pos_q),
    .t_o    (t)
  );

  // The bottom level has no children: they look empty and full.
  assign l = LAST ? ENTRY_EMPTY : dn.rd_l;
  assign r = LAST ? ENTRY_EMPTY : dn.rd_r;

  assign dn.start = start_dn;
  assign dn.op    = op_q;
  assign dn.kv    = out_dn;
  assign dn.pos   = {pos_q, endbit};
  assign dn.raddr = raddr_dn;

  // Next-state, node update and outputs; reset forces the idle defaults so a
  // token caught mid-EXEC is never forwarded.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    in_d     = in_q;
    pos_d    = pos_q;
    done     = DoneDone;
    active   = 1'b0;
    err      = 1'b0;
    start_dn = 1'b0;
    out_dn   = KV_EMPTY;
    we       = 1'b0;
    wdata    = t;
    endbit   = 1'b0;
    raddr_dn = pos_q;
    cap_dec  = (t.cap == '0) ? '0 : t.cap - CAP_ONE;
    cap_inc  = (t.cap >= RESET_CAP) ? RESET_CAP : t.cap + CAP_ONE;
    in_gt_t  = cmp_kv_entry_gt(in_q, t);
    l_room   = (l.cap != '0);
    r_room   = (r.cap != '0);

    if (rst_n) begin
      unique case (state_q)
        StIdle: begin
          if (up.start) begin
            op_d     = up.op;
            in_d     = up.kv;
            pos_d    = up.pos;
            active   = 1'b1;
            done     = DoneWait;
            raddr_dn = up.pos;
            state_d  = StExec;
          end
        end
        StExec: begin
          state_d = StIdle;
          active  = 1'b1;
          we      = 1'b1;
          unique case (op_q)
            OpLeq: begin
              if (!t.active) begin
                wdata = '{kv: in_q, cap: cap_dec, active: 1'b1};
                done  = DoneDone;
              end else begin
                wdata = '{kv: (in_gt_t ? in_q : t.kv), cap: cap_dec, active: 1'b1};
                if (LAST || (!l_room && !r_room)) begin
                  // Nowhere to push the loser: it is dropped.
                  done = DoneDone;
                  err  = (t.cap == '0);
                end else begin
                  done   = DoneNextLevel;
                  out_dn = in_gt_t ? t.kv : in_q;
                  endbit = (l_room && r_room) ? cmp_entry_entry_gt(l, r) : r_room;
                end
              end
            end
            OpDeq: begin
              if (!l.active && !r.active) begin
                wdata = '{kv: KV0, cap: cap_inc, active: 1'b0};
                done  = DoneDone;
              end else begin
                endbit = cmp_entry_entry_gt(r, l);
                wdata  = '{kv: (endbit ? r.kv : l.kv), cap: cap_inc, active: 1'b1};
                done   = DoneNextLevel;
              end
            end
            OpEnqDeq: begin
              if (cmp_kv_entry_gt(in_q, l) && cmp_kv_entry_gt(in_q, r)) begin
                wdata = '{kv: in_q, cap: t.cap, active: 1'b1};
                done  = DoneDone;
              end else begin
                // The larger child necessarily beats in_q here.
                endbit = cmp_entry_entry_gt(r, l);
                wdata  = '{kv: (endbit ? r.kv : l.kv), cap: t.cap, active: 1'b1};
                out_dn = in_q;
                done   = DoneNextLevel;
              end
            end
            default: begin
              we = 1'b0;
            end
          endcase
          start_dn = (done == DoneNextLevel);
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // FSM state and the latched token.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      op_q    <= OpLeq;
      in_q    <= KV_EMPTY;
      pos_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      in_q    <= in_d;
      pos_q   <= pos_d;
    end
  end

endmodule

// File: tb/tb_pheap_level.sv
// Bench for a level-2 stage with LEVELS = 3 (node reset capacity 3).
module tb_pheap_level;
  import pheap_level_pkg::*;

  logic  clk = 1'b0;
  logic  rst_n;
  done_t done;
  logic  active;
  logic  err;

  always #5 clk = ~clk;

  pheap_level_if #(.POS_W(1)) up_if ();
  pheap_level_if #(.POS_W(2)) dn_if ();

  pheap_level #(
    .LEVEL(2),
    .LAST (1'b0)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .up    (up_if),
    .dn    (dn_if),
    .done  (done),
    .active(active),
    .err   (err)
  );

  typedef struct {
    opcode_t    op;
    logic [7:0] key;
    logic       pos;
    entry_t     l;
    entry_t     r;
    done_t      done;
    kv_t        out;
    logic       eb;
    logic       err;
    entry_t     node;
  } vec_t;

  localparam entry_t RST_ENT = '{kv: KV_EMPTY, cap: 3'd3, active: 1'b0};

  vec_t        vecs[$];
  vec_t        sb[$];
  entry_t      exp_mem[2];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  function automatic kv_t kv(logic [7:0] k);
    return '{key: k, val: ~k};
  endfunction

  function automatic entry_t ent(logic [7:0] k, logic [2:0] c, logic a);
    return '{kv: kv(k), cap: c, active: a};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input opcode_t op, input logic [7:0] key, input logic pos,
                     input entry_t l, input entry_t r, input done_t d, input kv_t out,
                     input logic eb, input logic e, input entry_t node);
    vec_t v;
    v.op = op; v.key = key; v.pos = pos; v.l = l; v.r = r;
    v.done = d; v.out = out; v.eb = eb; v.err = e; v.node = node;
    vecs.push_back(v);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_done"}, done, DoneDone);
    chk({tag, "_active"}, active, 1'b0);
    chk({tag, "_start_dn"}, dn_if.start, 1'b0);
    chk({tag, "_rd_l"}, up_if.rd_l, exp_mem[0]);
    chk({tag, "_rd_r"}, up_if.rd_r, exp_mem[1]);
  endtask

  task automatic run_vec(input vec_t v);
    vec_t       e;
    logic [1:0] exp_pos;
    @(posedge clk); #1;
    up_if.start = 1'b1;
    up_if.op    = v.op;
    up_if.kv    = kv(v.key);
    up_if.pos   = v.pos;
    dn_if.rd_l  = v.l;
    dn_if.rd_r  = v.r;
    sb.push_back(v);
    @(negedge clk);
    chk("accept_done", done, DoneWait);
    chk("accept_active", active, 1'b1);
    chk("accept_raddr_dn", dn_if.raddr, v.pos);
    @(posedge clk); #1;
    up_if.start = 1'b0;
    @(negedge clk);
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard: got empty queue expected one entry");
    end else begin
      e       = sb.pop_front();
      exp_pos = {e.pos, e.eb};
      chk("exec_done", done, e.done);
      chk("exec_start_dn", dn_if.start, (e.done == DoneNextLevel));
      chk("exec_active", active, 1'b1);
      chk("exec_err", err, e.err);
      chk("exec_out_dn", dn_if.kv, e.out);
      chk("exec_raddr_dn", dn_if.raddr, e.pos);
      if (e.done == DoneNextLevel) begin
        chk("exec_pos_dn", dn_if.pos, exp_pos);
        chk("exec_op_dn", dn_if.op, e.op);
      end
      chk("exec_bypass", e.pos ? up_if.rd_r : up_if.rd_l, e.node);
      exp_mem[e.pos] = e.node;
    end
    @(posedge clk);
    @(negedge clk);
    chk_idle("after");
  endtask

  initial begin
    vec_t v;
    rst_n       = 1'b0;
    up_if.start = 1'b0;
    up_if.op    = OpLeq;
    up_if.kv    = KV_EMPTY;
    up_if.pos   = 1'b0;
    up_if.raddr = 1'b0;
    dn_if.rd_l  = ENTRY_EMPTY;
    dn_if.rd_r  = ENTRY_EMPTY;
    exp_mem[0]  = RST_ENT;
    exp_mem[1]  = RST_ENT;

    //  op        key    pos  L                  R                  done           out_dn    eb    err   node
    add(OpLeq,    8'h50, 0, ent(8'h00,1,0), ent(8'h00,1,0), DoneDone,      KV_EMPTY, 1'b0, 1'b0, ent(8'h50,2,1));
    add(OpLeq,    8'h70, 0, ent(8'h00,1,0), ent(8'h00,1,0), DoneNextLevel, kv(8'h50), 1'b0, 1'b0, ent(8'h70,1,1));
    add(OpLeq,    8'h40, 1, ent(8'h00,1,0), ent(8'h00,1,0), DoneDone,      KV_EMPTY, 1'b0, 1'b0, ent(8'h40,2,1));
    add(OpDeq,    8'h00, 1, ent(8'h30,0,1), ent(8'h35,0,1), DoneNextLevel, KV_EMPTY, 1'b1, 1'b0, ent(8'h35,3,1));
    add(OpDeq,    8'h00, 1, ent(8'h00,1,0), ent(8'h00,1,0), DoneDone,      KV_EMPTY, 1'b0, 1'b0,
        '{kv: KV0, cap: 3'd3, active: 1'b0});
    add(OpEnqDeq, 8'h20, 0, ent(8'h30,1,1), ent(8'h10,1,1), DoneNextLevel, kv(8'h20), 1'b0, 1'b0, ent(8'h30,1,1));
    add(OpEnqDeq, 8'h90, 0, ent(8'h30,1,1), ent(8'h10,1,1), DoneDone,      KV_EMPTY, 1'b0, 1'b0, ent(8'h90,1,1));
    add(OpLeq,    8'h60, 0, ent(8'h30,0,1), ent(8'h00,1,0), DoneNextLevel, kv(8'h60), 1'b1, 1'b0, ent(8'h90,0,1));
    add(OpLeq,    8'h10, 0, ent(8'h30,0,1), ent(8'h20,0,1), DoneDone,      KV_EMPTY, 1'b0, 1'b1, ent(8'h90,0,1));
    add(OpLeq,    8'hA0, 0, ent(8'h08,1,1), ent(8'h05,1,1), DoneNextLevel, kv(8'h90), 1'b1, 1'b0, ent(8'hA0,0,1));
    add(OpEnqDeq, 8'h44, 1, ent(8'h00,1,0), ent(8'h50,1,1), DoneNextLevel, kv(8'h44), 1'b1, 1'b0, ent(8'h50,3,1));
    add(OpDeq,    8'h00, 1, ent(8'h60,0,1), ent(8'h00,1,0), DoneNextLevel, KV_EMPTY, 1'b0, 1'b0, ent(8'h60,3,1));
    add(OpLeq,    8'h30, 1, ent(8'h00,1,0), ent(8'h00,1,0), DoneNextLevel, kv(8'h30), 1'b0, 1'b0, ent(8'h60,2,1));

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk_idle("reset");
    chk("reset_err", err, 1'b0);

    foreach (vecs[i]) begin
      run_vec(vecs[i]);
    end

    // Reset during EXEC of a token that would otherwise be forwarded.
    @(posedge clk); #1;
    up_if.start = 1'b1;
    up_if.op    = OpLeq;
    up_if.kv    = kv(8'h11);
    up_if.pos   = 1'b0;
    dn_if.rd_l  = ent(8'h00, 1, 0);
    dn_if.rd_r  = ent(8'h00, 1, 0);
    @(posedge clk); #1;
    up_if.start = 1'b0;
    rst_n       = 1'b0;
    @(negedge clk);
    chk("rst_exec_start_dn", dn_if.start, 1'b0);
    chk("rst_exec_done", done, DoneDone);
    chk("rst_exec_active", active, 1'b0);
    @(posedge clk); #1;
    rst_n      = 1'b1;
    exp_mem[0] = RST_ENT;
    exp_mem[1] = RST_ENT;
    @(negedge clk);
    chk_idle("rst_exec");

    // The stage must accept a fresh token straight after reset.
    v.op = OpLeq; v.key = 8'h55; v.pos = 1'b1;
    v.l = ent(8'h00, 1, 0); v.r = ent(8'h00, 1, 0);
    v.done = DoneDone; v.out = KV_EMPTY; v.eb = 1'b0; v.err = 1'b0;
    v.node = ent(8'h55, 2, 1);
    run_vec(v);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish before 100000");
    $fatal(1);
  end

endmodule
